// File: rtl/calc_pkg.sv
// calc_pkg: op and state encodings, seven-segment font table and BCD sizing helper
// shared by fnd_calc_seq and bin2bcd_seq.
package calc_pkg;
    typedef enum logic [1:0] {ADD, SUB, MUL, DIV} op_e;
    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_e;
    // active-low gfedcba, digit 9 in the top byte down to digit 0 in the bottom byte
    localparam logic [79:0] FONT_LUT = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    localparam logic [7:0] FONT_DASH = 8'hBF;
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    // decimal digits needed for 2^bits-1 (log10(2) ~ 0.301)
    function automatic int bcd_digits(input int bits);
        return bits * 301 / 1000 + 1;
    endfunction
    function automatic logic [7:0] font_of(input logic [3:0] n);
        return n > 4'd9 ? FONT_BLANK : FONT_LUT[8*n +: 8];
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one input bit per cycle; done pulses for one
// cycle when bcd holds the final value, which then stays until the next start.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int BITS = 16,
    parameter int ND = bcd_digits(BITS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [4*ND-1:0] bcd
);
    localparam int SW = 4*ND + BITS;
    localparam int CW = $clog2(BITS + 1);
    logic [SW-1:0] sr, adj;
    logic [CW-1:0] cnt;
    always_comb begin
        adj = sr;
        for (int i = 0; i < ND; i++)
            if (sr[BITS+4*i +: 4] >= 4'd5) adj[BITS+4*i +: 4] = sr[BITS+4*i +: 4] + 4'd3;
    end
    // the load edge also performs the first shift: the BCD field is still zero, so no adjust
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sr <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                sr <= SW'(bin) << 1;
                cnt <= CW'(1);
                busy <= 1'b1;
            end else if (busy) begin
                sr <= adj << 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(BITS - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    assign bcd = sr[SW-1 -: 4*ND];
endmodule

// File: rtl/fnd_calc_seq.sv
// fnd_calc_seq: clocked add/sub/mul/restoring-div calculator with BCD conversion and a
// self-scanning seven-segment driver. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module fnd_calc_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGITS = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [1:0]        i_select,
    input  logic              i_start,
    input  logic              i_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_neg,
    output logic [DIGITS-1:0] o_digit,
    output logic [7:0]        o_font
);
    localparam int W2 = 2 * WIDTH;
    localparam int ND = bcd_digits(W2);
    localparam int NP = ND > DIGITS ? ND : DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int IW = $clog2(DIGITS + 1);
    state_e state, state_n;
    op_e op;
    logic [WIDTH-1:0] a, b, rem, rem_n, q_n;
    logic [WIDTH:0] shifted, trial;
    logic [CW-1:0] cnt;
    logic [W2-1:0] res, calc_res;
    logic calc_last, conv_start, conv_busy, conv_done, d_err, d_neg, blank;
    logic [4*ND-1:0] bcd;
    logic [4*NP-1:0] bcd_ext;
    logic [4*DIGITS-1:0] disp;
    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    logic [3:0] nib;
    bin2bcd_seq #(.BITS(W2), .ND(ND)) u_bcd (
        .clk(i_clk), .rst(i_reset), .start(conv_start), .bin(res),
        .busy(conv_busy), .done(conv_done), .bcd(bcd)
    );
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) state <= IDLE;
        else state <= state_n;
    // during division `a` doubles as the quotient shift register
    always_comb begin
        shifted = {rem, a[WIDTH-1]};
        trial = shifted - (WIDTH+1)'(b);
        q_n = {a[WIDTH-2:0], ~trial[WIDTH]};
        rem_n = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        calc_res = op == ADD ? W2'(a) + W2'(b) :
                   op == SUB ? (a < b ? W2'(b - a) : W2'(a - b)) :
                   op == MUL ? W2'(a) * W2'(b) :
                   b == '0 ? '0 : W2'(q_n);
        calc_last = op != DIV || b == '0 || cnt == CW'(WIDTH - 1);
        state_n = state == IDLE && i_start ? CALC :
                  state == CALC && calc_last ? CONV :
                  state == CONV && conv_done ? DONE :
                  state == DONE ? IDLE : state;
        o_busy = state != IDLE;
        o_done = state == DONE;
        conv_start = state == CONV && !conv_busy && !conv_done;
        bcd_ext = (4*NP)'(bcd);
    end
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            a <= '0;
            b <= '0;
            op <= ADD;
            rem <= '0;
            cnt <= '0;
            res <= '0;
            o_err <= 1'b0;
            o_neg <= 1'b0;
            disp <= '0;
            d_err <= 1'b0;
            d_neg <= 1'b0;
        end else begin
            if (state == IDLE && i_start) begin
                a <= i_a;
                b <= i_b;
                op <= op_e'(i_select);
                rem <= '0;
                cnt <= '0;
                o_err <= 1'b0;
                o_neg <= 1'b0;
            end
            if (state == CALC) begin
                a <= q_n;
                rem <= rem_n;
                cnt <= cnt + 1'b1;
                res <= calc_res;
                o_neg <= op == SUB && a < b;
                o_err <= op == DIV && b == '0;
            end
            if (state == CONV && conv_done) o_err <= o_err | (|(bcd_ext >> (4*DIGITS)));
            if (state == DONE) begin
                disp <= bcd_ext[4*DIGITS-1:0];
                d_err <= o_err;
                d_neg <= o_neg;
            end
        end
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre == PW'(SCAN_DIV - 1) ? '0 : pre + 1'b1;
            if (pre == PW'(SCAN_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
        end
    always_comb begin
        nib = disp[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = idx != '0 && (disp >> (4*idx)) == '0;
`else
        blank = 1'b0;
`endif
        o_font = d_err ? FONT_DASH : blank ? FONT_BLANK : font_of(nib);
        if (d_neg && idx == IW'(DIGITS - 1)) o_font[7] = 1'b0;
        o_digit = i_en ? ~(DIGITS'(1) << idx) : '1;
    end
endmodule

// File: tb/tb_fnd_calc_seq.sv
// tb_fnd_calc_seq: scoreboard bench for fnd_calc_seq (WIDTH=8, DIGITS=4, SCAN_DIV=4);
// expected display/flags/latency are queued at start and compared when o_done fires.
module tb_fnd_calc_seq;
    localparam int WIDTH = 8;
    localparam int DIGITS = 4;
    localparam int SCAN_DIV = 4;
    typedef struct packed {
        logic [8*DIGITS-1:0] fonts;
        logic err;
        logic neg;
        logic [7:0] lat;
    } exp_t;
    logic clk = 0;
    logic i_reset, i_start, i_en;
    logic [WIDTH-1:0] i_a, i_b;
    logic [1:0] i_select;
    logic o_busy, o_done, o_err, o_neg;
    logic [DIGITS-1:0] o_digit;
    logic [7:0] o_font;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    fnd_calc_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_a(i_a), .i_b(i_b), .i_select(i_select),
        .i_start(i_start), .i_en(i_en), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_neg(o_neg), .o_digit(o_digit), .o_font(o_font)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    // latency counts the cycle after the start edge as N+1
    function automatic exp_t model(input int x, input int y, input int s);
        exp_t e;
        int r, p;
        logic [7:0] f;
        e = '0;
        e.lat = 8'd19;
        case (s)
            0: r = x + y;
            1: begin r = x < y ? y - x : x - y; e.neg = x < y; end
            2: r = x * y;
            default: if (y == 0) begin r = 0; e.err = 1; end else begin r = x / y; e.lat = 8'd26; end
        endcase
        if (r > 9999) e.err = 1;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            f = e.err ? 8'hBF : lut[(r / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (!e.err && d > 0 && r < p) f = 8'hFF;
`endif
            if (e.neg && d == DIGITS - 1) f[7] = 1'b0;
            e.fonts[8*d +: 8] = f;
            p = p * 10;
        end
        return e;
    endfunction
    task automatic check_display(input exp_t e);
        logic [DIGITS-1:0] seen;
        seen = '0;
        for (int c = 0; c < 3 * DIGITS * SCAN_DIV; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < DIGITS; d++)
                if (o_digit === ~(DIGITS'(1) << d) && !seen[d]) begin
                    seen[d] = 1'b1;
                    checks++;
                    if (o_font !== e.fonts[8*d +: 8]) begin
                        errors++;
                        $display("FAIL font_digit%0d: got %h want %h", d, o_font, e.fonts[8*d +: 8]);
                    end
                end
        end
        checks++;
        if (seen !== '1) begin
            errors++;
            $display("FAIL digit_scan_coverage: got %b want %b", seen, {DIGITS{1'b1}});
        end
    endtask
    task automatic start_op(input int x, input int y, input int s);
        @(negedge clk);
        i_a = WIDTH'(x);
        i_b = WIDTH'(y);
        i_select = 2'(s);
        i_start = 1;
        @(posedge clk);
        #1 i_start = 0;
    endtask
    task automatic run_op(input int x, input int y, input int s);
        exp_t e;
        int k;
        exp_q.push_back(model(x, y, s));
        start_op(x, y, s);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", o_busy); end
        k = 0;
        while (o_done !== 1'b1 && k < 60) begin @(posedge clk); #1; k++; end
        e = exp_q.pop_front();
        checks++;
        if (k + 1 !== int'(e.lat)) begin errors++; $display("FAIL done_latency: got N+%0d want N+%0d", k + 1, e.lat); end
        checks++;
        if (o_err !== e.err) begin errors++; $display("FAIL err_flag: got %b want %b", o_err, e.err); end
        checks++;
        if (o_neg !== e.neg) begin errors++; $display("FAIL neg_flag: got %b want %b", o_neg, e.neg); end
        @(posedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: got busy=%b done=%b want 0 0", o_busy, o_done);
        end
        check_display(e);
    endtask
    task automatic test_reset;
        checks++;
        if ({o_busy, o_done, o_err, o_neg} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {o_busy, o_done, o_err, o_neg});
        end
        checks++;
        if (o_digit !== 4'b1110) begin errors++; $display("FAIL reset_digit: got %b want 1110", o_digit); end
        check_display(model(0, 0, 0));
    endtask
    task automatic test_add;
        run_op(200, 55, 0);
    endtask
    task automatic test_sub;
        run_op(5, 9, 1);
        run_op(9, 5, 1);
    endtask
    task automatic test_overflow;
        run_op(255, 255, 2);
        run_op(200, 0, 3);
        run_op(99, 99, 2);
    endtask
    task automatic test_div;
        run_op(200, 7, 3);
        run_op(255, 1, 3);
        run_op(3, 200, 3);
    endtask
    task automatic test_back_to_back;
        exp_t e;
        int dones, first;
        exp_q.push_back(model(12, 30, 0));
        start_op(12, 30, 0);
        dones = 0;
        first = -1;
        for (int k = 0; k < 50; k++) begin
            if (k == 4) begin @(negedge clk); i_a = 8'd1; i_b = 8'd2; i_select = 2'd1; i_start = 1; end
            if (k == 5) i_start = 0;
            if (o_done === 1'b1) begin dones++; if (first < 0) first = k; end
            @(posedge clk);
            #1;
        end
        e = exp_q.pop_front();
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
        checks++;
        if (first + 1 !== int'(e.lat)) begin errors++; $display("FAIL b2b_latency: got N+%0d want N+%0d", first + 1, e.lat); end
        checks++;
        if (o_busy !== 1'b0 || o_neg !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored_start: got busy=%b neg=%b want 0 0", o_busy, o_neg);
        end
        check_display(e);
    endtask
    task automatic test_reset_mid;
        int dones;
        start_op(200, 7, 3);
        repeat (3) @(posedge clk);
        #2 i_reset = 1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b want 0 0", o_busy, o_done);
        end
        @(negedge clk);
        i_reset = 0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (o_done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done: got dones=%0d err=%b want 0 0", dones, o_err);
        end
        check_display(model(0, 0, 0));
    endtask
    task automatic test_scan;
        logic [DIGITS-1:0] prev, want;
        int found;
        found = 0;
        @(posedge clk);
        #1 prev = o_digit;
        for (int k = 0; k < 4 * DIGITS * SCAN_DIV && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (prev === 4'b0111 && o_digit === 4'b1110) found = 1;
            prev = o_digit;
        end
        checks++;
        if (found !== 1) begin errors++; $display("FAIL scan_wrap: got %0d want 1 (0111->1110 seen)", found); end
        for (int i = 1; i < 36; i++) begin
            @(posedge clk);
            #1;
            want = i >= 20 && i < 28 ? 4'b1111 : ~(DIGITS'(1) << ((i / SCAN_DIV) % DIGITS));
            checks++;
            if (o_digit !== want) begin errors++; $display("FAIL scan_step%0d: got %b want %b", i, o_digit, want); end
            if (i == 19) i_en = 0;
            if (i == 27) i_en = 1;
        end
    endtask
    initial begin
        i_reset = 1;
        i_start = 0;
        i_en = 1;
        i_a = '0;
        i_b = '0;
        i_select = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_reset = 0;
        test_reset;
        test_add;
        test_sub;
        test_overflow;
        test_div;
        test_back_to_back;
        test_reset_mid;
        test_scan;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fnd_calc_seq.md
Name: fnd_calc_seq

Overview:
Parametrised, clocked successor to the combinational calculator/FND pair.
- Captures two WIDTH-bit operands on a start strobe and computes add, sub, mul or div; division is iterative (restoring).
- Converts the result to BCD with a sequential double-dabble.
- Drives a DIGITS-wide seven-segment display with autonomous time-multiplexed scanning, so no external digit select is needed.
- Sits between the board switches/buttons and the FND pins.

Parameters:
WIDTH, 8, operand width in bits (≥2)
DIGITS, 4, number of FND digits scanned (1..8)
SCAN_DIV, 100000, clock cycles each digit stays active (≥1)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_a  in  WIDTH  operand A, unsigned
i_b  in  WIDTH  operand B, unsigned
i_select  in  2  op: 00 add, 01 sub, 10 mul, 11 div (quotient)
i_start  in  1  start strobe, sampled only in IDLE
i_en  in  1  display enable; 0 blanks all digits
o_busy  out  1  high from the cycle after start until DONE exits
o_done  out  1  one-cycle pulse when the result is latched to the display
o_err  out  1  sticky until next start: divide-by-zero or decimal overflow
o_neg  out  1  sub result negative (a<b)
o_digit  out  DIGITS  digit enables, active-low one-hot
o_font  out  8  segments, active-low, bit7=dp, bits6..0=g..a

Behaviour:
- Clock and reset: single clock i_clk; i_reset is asynchronous and active-high.
- Reset values: FSM=IDLE; o_busy=0; o_done=0; o_err=0; o_neg=0; display register=0; scan index=0; prescaler=0.
- FSM states: IDLE→CALC→CONV→DONE→IDLE.
- IDLE:
  - When i_start=1 at edge N, latch i_a, i_b and i_select, then go to CALC.
  - o_err and o_neg clear at the same edge.
- CALC, width rules:
  - Result register is 2*WIDTH bits.
  - add: zero-extended sum.
  - sub: |a−b|, o_neg=(a<b).
  - mul: full product.
  - div: quotient floor(a/b).
- CALC, duration:
  - add/sub/mul take 1 cycle.
  - div takes WIDTH cycles, one quotient bit per cycle, MSB first.
  - b=0 on div: skip iteration, set o_err, go directly to CONV with result=0.
- CONV:
  - Double-dabble over 2*WIDTH cycles into enough BCD nibbles to hold 2^(2*WIDTH)−1.
  - If any nibble at index ≥DIGITS is nonzero, set o_err.
- DONE: one cycle; o_done=1; latch the low DIGITS BCD nibbles plus o_err/o_neg into the display register; next state IDLE.
- Latency from start edge N:
  - o_done is high in cycle N+2+C+2*WIDTH, with C=1 for add/sub/mul and C=WIDTH for div.
  - WIDTH=8: add/sub/mul → N+19; div → N+26.
- o_busy is high from cycle N+1 through the DONE cycle.
- i_start while o_busy=1 is ignored; no queuing.
- Reset mid-operation returns to IDLE immediately and clears the display register; no o_done is emitted.
- Scan:
  - The prescaler counts 0..SCAN_DIV−1 continuously, independent of the FSM.
  - On wrap, the index increments, wrapping DIGITS−1→0.
  - Digit 0 is the least significant.
- Output decode:
  - o_digit = ~(1<<index) when i_en=1, else all ones.
  - o_font decodes the selected nibble: 0–9 to the standard font, active-low.
- Error display: if o_err is latched, every digit shows '-' (font 8'hBF).
- Sign display: if o_neg is latched, the dp of digit DIGITS−1 is lit (bit7=0).
- The display holds its value until the next DONE or reset.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits above the most significant nonzero digit show blank (8'hFF); digit 0 always shows, so a value of 0 shows a single "0". Error dashes are not blanked.
- Undefined: all DIGITS digits show, including leading zeros (e.g. "0028").

Decomposition:
- Package calc_pkg:
  - op encodings ADD/SUB/MUL/DIV
  - FSM state enum
  - font constants: 0–9 LUT, FONT_DASH=8'hBF, FONT_BLANK=8'hFF
- Sub-module bin2bcd_seq: start/busy/done handshake, 2*WIDTH-cycle double-dabble, parametrised by input width.
- Divider, FSM and scan logic stay in the top.

Test Plan:
All scenarios use WIDTH=8, DIGITS=4, SCAN_DIV=4.
1. add 200+55, start at N → o_done at N+19; display nibbles 0,2,5,5; o_err=0; LSB digit font 8'h92.
2. sub 5−9 → magnitude 4; o_neg=1; digit 3 font has bit7=0; digit 0 font 8'h99.
3. mul 255×255=65025 → o_err=1; all four digits show 8'hBF; div 200/0 → o_err=1 and dashes, with no divider iteration.
4. div 200/7 → o_done at N+26; value 28; check with and without LEADING_ZERO_BLANK_EN (digits 3,2 blank vs '0').
5. i_start pulsed during CONV → ignored, single o_done. Reset asserted mid-CALC → o_busy=0 asynchronously, no o_done, display shows 0.
6. Scan → o_digit steps 1110→1101→1011→0111→1110, each held 4 cycles; i_en=0 → o_digit=1111 while the index keeps counting.
